// File: rtl/pulse_freq_meter.sv
// rtl/pulse_freq_meter.sv - edge-count frequency and rising-edge period meter for an asynchronous pulse train
module pulse_freq_meter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int CNT_W       = 16,
    parameter int PER_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             stalled,
    output logic             ovf
);

    localparam int               GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [PER_W-1:0]  PER_MAX   = '1;

    logic              s1;
    logic              s2;
    logic              s3;
    logic              edge_det;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              sat;
    logic [PER_W-1:0]  per_cnt;
    logic              first_seen;

    logic              terminal;
    logic [CNT_W-1:0]  cnt_final;
    logic              sat_final;
    logic [PER_W-1:0]  per_inc;

    // Rising edge of the synchronised input, one cycle wide.
    assign edge_det = s2 & ~s3;

    // Two-flop synchroniser plus history flop; runs regardless of en so the
    // first enabled cycle already sees a settled input.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pulse_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Saturating next values: the count including this cycle's edge, the sticky
    // overflow flag, and the period counter advanced by one.
    always_comb begin
        terminal  = (gate_cnt == GATE_LAST);
        cnt_final = edge_cnt;
        sat_final = sat;
        if (edge_det) begin
            if (edge_cnt == CNT_MAX) begin
                sat_final = 1'b1;
            end else begin
                cnt_final = edge_cnt + 1'b1;
            end
        end
        per_inc = (per_cnt == PER_MAX) ? PER_MAX : per_cnt + 1'b1;
    end

    // Gate window: count edges, publish the closing count on the terminal cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            freq       <= '0;
            freq_valid <= 1'b0;
            stalled    <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if (!en) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
            end else if (terminal) begin
                gate_cnt   <= '0;
                edge_cnt   <= '0;
                sat        <= 1'b0;
                freq       <= cnt_final;
                ovf        <= sat_final;
                stalled    <= (cnt_final == '0);
                freq_valid <= 1'b1;
            end else begin
                gate_cnt <= gate_cnt + 1'b1;
                edge_cnt <= cnt_final;
                sat      <= sat_final;
            end
        end
    end

    // Period: cycles between consecutive edges; the first edge only arms the measurement.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt      <= '0;
            first_seen   <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (!en) begin
                per_cnt    <= '0;
                first_seen <= 1'b0;
            end else if (edge_det) begin
                per_cnt    <= '0;
                first_seen <= 1'b1;
                if (first_seen) begin
                    period       <= per_inc;
                    period_valid <= 1'b1;
                end
            end else begin
                per_cnt <= per_inc;
            end
        end
    end

endmodule
